// File: rtl/crc_byte_packer.sv
// Packs a framed byte stream into 16-bit words (first byte high) and queues them
// in a show-ahead FIFO; also reports each completed frame's byte length.
module crc_byte_packer #(
  parameter int DEPTH = 4,
  parameter bit REVIN = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic [7:0]               byte_i,
  input  logic                     byte_valid_i,
  input  logic                     byte_last_i,
  output logic                     byte_ready_o,
  output logic [15:0]              word_o,
  output logic                     word_odd_o,
  output logic                     word_last_o,
  output logic                     word_valid_o,
  input  logic                     word_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [15:0]              frame_len_o,
  output logic                     frame_done_o
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        last;
    logic        odd;
    logic [15:0] word;
  } entry_t;

  // Handshakes: a byte moves when byte_valid_i & byte_ready_o at a rising edge;
  // a word moves when word_valid_o & word_ready_i at a rising edge.
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_vld_q, hold_vld_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     frame_len_q, frame_len_d;
  logic            done_q, done_d;

  logic [7:0]      byte_in;
  logic            full, empty, accept, push, pop;
  logic [15:0]     cnt_inc;
  entry_t          push_entry;

  always_comb begin
    byte_in = byte_i;
    if (REVIN) begin
      for (int i = 0; i < 8; i++) byte_in[i] = byte_i[7-i];
    end
  end

  // Ready depends only on registered occupancy, never on the byte inputs.
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign accept  = byte_valid_i & ~full;
  assign push    = accept & (hold_vld_q | byte_last_i);
  assign pop     = ~empty & word_ready_i;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    if (hold_vld_q) begin
      push_entry = '{last: byte_last_i, odd: 1'b0, word: {hold_q, byte_in}};
    end else begin
      push_entry = '{last: 1'b1, odd: 1'b1, word: {byte_in, 8'h00}};
    end
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    cnt_d       = cnt_q;
    frame_len_d = frame_len_q;
    done_d      = 1'b0;
    if (clr_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      hold_vld_d = 1'b0;
      cnt_d      = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
      if (accept) begin
        cnt_d = cnt_inc;
        if (byte_last_i) begin
          frame_len_d = cnt_inc;
          cnt_d       = '0;
          done_d      = 1'b1;
          hold_vld_d  = 1'b0;
        end else if (hold_vld_q) begin
          hold_vld_d = 1'b0;
        end else begin
          hold_d     = byte_in;
          hold_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      cnt_q       <= '0;
      frame_len_q <= '0;
      done_q      <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      cnt_q       <= cnt_d;
      frame_len_q <= frame_len_d;
      done_q      <= done_d;
    end
  end

  assign byte_ready_o = ~full;
  assign word_valid_o = ~empty;
  assign word_o       = mem_q[rd_ptr_q].word;
  assign word_odd_o   = mem_q[rd_ptr_q].odd;
  assign word_last_o  = mem_q[rd_ptr_q].last;
  assign level_o      = level_q;
  assign frame_len_o  = frame_len_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_crc_byte_packer.sv
// Bench for crc_byte_packer: directed steps plus random frames, compared against
// a queue-based reference of the packing rules.
module tb_crc_byte_packer;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_i, clr_i;
  logic [7:0]    byte_i;
  logic          byte_valid_i, byte_last_i, byte_ready_o;
  logic [15:0]   word_o;
  logic          word_odd_o, word_last_o, word_valid_o, word_ready_i;
  logic [LW-1:0] level_o;
  logic [15:0]   frame_len_o;
  logic          frame_done_o;

  logic [7:0]    r_byte;
  logic          r_valid, r_last, r_ready, r_odd, r_last_o, r_wvalid, r_wready, r_done;
  logic [15:0]   r_word, r_len;
  logic [LW-1:0] r_level;
  logic          r_clr;

  always #5 clk = ~clk;

  crc_byte_packer #(.DEPTH(DEPTH), .REVIN(1'b0)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_last_i(byte_last_i),
    .byte_ready_o(byte_ready_o), .word_o(word_o), .word_odd_o(word_odd_o),
    .word_last_o(word_last_o), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .level_o(level_o), .frame_len_o(frame_len_o), .frame_done_o(frame_done_o)
  );

  crc_byte_packer #(.DEPTH(DEPTH), .REVIN(1'b1)) dut_r (
    .clk_i(clk), .rst_i(rst_i), .clr_i(r_clr),
    .byte_i(r_byte), .byte_valid_i(r_valid), .byte_last_i(r_last),
    .byte_ready_o(r_ready), .word_o(r_word), .word_odd_o(r_odd),
    .word_last_o(r_last_o), .word_valid_o(r_wvalid), .word_ready_i(r_wready),
    .level_o(r_level), .frame_len_o(r_len), .frame_done_o(r_done)
  );

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];
  logic [17:0] popped_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  hold_m;
  bit          hold_v_m;
  int          cnt_m;
  logic [15:0] len_m;
  bit          done_m;
  bit          full_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: words are the frame's bytes taken in pairs; an odd tail byte
  // becomes {b,00} with odd set. Entries are {last, odd, word}.
  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      hold_v_m = 1'b0;
      cnt_m    = 0;
      len_m    = '0;
      done_m   = 1'b0;
    end else begin
      chk("level", 32'(level_o), 32'(exp_q.size()));
      chk("word_valid", 32'(word_valid_o), 32'(exp_q.size() != 0));
      chk("byte_ready", 32'(byte_ready_o), 32'(exp_q.size() < DEPTH));
      chk("frame_done", 32'(frame_done_o), 32'(done_m));
      chk("frame_len", 32'(frame_len_o), 32'(len_m));
      if (exp_q.size() != 0) chk("head", 32'({word_last_o, word_odd_o, word_o}), 32'(exp_q[0]));
      done_m = 1'b0;
      if (clr_i) begin
        exp_q.delete();
        hold_v_m = 1'b0;
        cnt_m    = 0;
      end else begin
        full_m = (exp_q.size() >= DEPTH);
        if (exp_q.size() != 0 && word_ready_i) begin
          popped_q.push_back({word_last_o, word_odd_o, word_o});
          void'(exp_q.pop_front());
        end
        if (byte_valid_i && !full_m) begin
          cnt_m++;
          if (hold_v_m) begin
            exp_q.push_back({byte_last_i, 1'b0, hold_m, byte_i});
            hold_v_m = 1'b0;
          end else if (byte_last_i) begin
            exp_q.push_back({2'b11, byte_i, 8'h00});
          end else begin
            hold_m   = byte_i;
            hold_v_m = 1'b1;
          end
          if (byte_last_i) begin
            len_m    = (cnt_m > 65535) ? 16'hFFFF : 16'(cnt_m);
            cnt_m    = 0;
            done_m   = 1'b1;
            hold_v_m = 1'b0;
          end
        end
      end
    end
  end

  // Streams tx_q[start..] one byte per accepted handshake; consumer ready is
  // random with the given percentage.
  task automatic send_tx(input int pct, input bit use_last, input int start);
    int idx = start;
    int guard = 0;
    while (idx < tx_q.size() && guard < 2000) begin
      tick();
      byte_valid_i = 1'b1;
      byte_i       = tx_q[idx];
      byte_last_i  = use_last && (idx == tx_q.size() - 1);
      word_ready_i = ($urandom_range(99) < pct);
      @(negedge clk);
      if (byte_ready_o) idx++;
      guard++;
    end
    tick();
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    chk("send_bound", 32'(guard < 2000), 32'd1);
  endtask

  task automatic drain();
    int guard = 0;
    word_ready_i = 1'b1;
    while (guard < 100) begin
      tick();
      @(negedge clk);
      if (!word_valid_o) break;
      guard++;
    end
    chk("drain_bound", 32'(guard < 100), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    int n;
    rst_i = 1'b1; clr_i = 1'b0; byte_i = '0; byte_valid_i = 1'b0; byte_last_i = 1'b0;
    word_ready_i = 1'b0;
    r_byte = '0; r_valid = 1'b0; r_last = 1'b0; r_wready = 1'b0; r_clr = 1'b0;
    @(negedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_valid", 32'(word_valid_o), 32'd0);
    chk("rst_ready", 32'(byte_ready_o), 32'd1);
    chk("rst_len", 32'(frame_len_o), 32'd0);
    chk("rst_done", 32'(frame_done_o), 32'd0);

    // Even frame
    popped_q.delete();
    tx_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    send_tx(100, 1'b1, 0);
    @(negedge clk);
    chk("f1_done", 32'(frame_done_o), 32'd1);
    chk("f1_len", 32'(frame_len_o), 32'd4);
    tick();
    @(negedge clk);
    chk("f1_done_off", 32'(frame_done_o), 32'd0);
    drain();
    chk("f1_cnt", 32'(popped_q.size()), 32'd2);
    chk("f1_w0", 32'(popped_q[0]), 32'h01234);
    chk("f1_w1", 32'(popped_q[1]), 32'h25678);

    // Odd frame, then single-byte frame
    popped_q.delete();
    tx_q = '{8'hAB, 8'hCD, 8'hEF};
    send_tx(100, 1'b1, 0);
    drain();
    chk("f2_len", 32'(frame_len_o), 32'd3);
    chk("f2_w0", 32'(popped_q[0]), 32'h0ABCD);
    chk("f2_w1", 32'(popped_q[1]), 32'h3EF00);
    popped_q.delete();
    tx_q = '{8'h5A};
    send_tx(100, 1'b1, 0);
    drain();
    chk("f3_len", 32'(frame_len_o), 32'd1);
    chk("f3_cnt", 32'(popped_q.size()), 32'd1);
    chk("f3_w0", 32'(popped_q[0]), 32'h35A00);

    // Reflected input on the second instance
    tick(); r_valid = 1'b1; r_byte = 8'h01; r_last = 1'b0;
    tick(); r_byte = 8'h80; r_last = 1'b1;
    tick(); r_valid = 1'b0; r_last = 1'b0;
    @(negedge clk);
    chk("rev_valid", 32'(r_wvalid), 32'd1);
    chk("rev_word", 32'(r_word), 32'h8001);
    chk("rev_odd", 32'(r_odd), 32'd0);
    chk("rev_last", 32'(r_last_o), 32'd1);
    chk("rev_len", 32'(r_len), 32'd2);
    chk("rev_done", 32'(r_done), 32'd1);

    // Backpressure: fill, stall, single pop, then 20 words across pointer wrap
    popped_q.delete();
    word_ready_i = 1'b0;
    tx_q.delete();
    for (int i = 0; i < 40; i++) tx_q.push_back(8'($urandom));
    for (int i = 0; i < 8; i++) begin
      tick();
      byte_valid_i = 1'b1; byte_i = tx_q[i]; byte_last_i = 1'b0;
      @(negedge clk);
      chk("bp_fill_ready", 32'(byte_ready_o), 32'd1);
    end
    tick();
    byte_i = tx_q[8];
    @(negedge clk);
    chk("bp_full_level", 32'(level_o), 32'd4);
    chk("bp_full_ready", 32'(byte_ready_o), 32'd0);
    tick();
    @(negedge clk);
    chk("bp_stall_ready", 32'(byte_ready_o), 32'd0);
    tick();
    word_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_pop_ready", 32'(byte_ready_o), 32'd0);
    tick();
    word_ready_i = 1'b0;
    @(negedge clk);
    chk("bp_after_pop_ready", 32'(byte_ready_o), 32'd1);
    chk("bp_after_pop_level", 32'(level_o), 32'd3);
    send_tx(50, 1'b1, 9);
    drain();
    chk("bp_cnt", 32'(popped_q.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      chk("bp_word", 32'(popped_q[i]), 32'({(i == 19), 1'b0, tx_q[2*i], tx_q[2*i+1]}));
    end
    chk("bp_len", 32'(frame_len_o), 32'd40);

    // Flush with hold full and two words queued; a byte offered alongside is dropped
    popped_q.delete();
    tx_q.delete();
    for (int i = 0; i < 5; i++) tx_q.push_back(8'($urandom));
    send_tx(0, 1'b0, 0);
    @(negedge clk);
    chk("clr_pre_level", 32'(level_o), 32'd2);
    tick();
    clr_i = 1'b1; byte_valid_i = 1'b1; byte_i = 8'h99;
    @(negedge clk);
    tick();
    clr_i = 1'b0; byte_valid_i = 1'b0;
    @(negedge clk);
    chk("clr_level", 32'(level_o), 32'd0);
    chk("clr_valid", 32'(word_valid_o), 32'd0);
    chk("clr_len_kept", 32'(frame_len_o), 32'd40);
    tx_q = '{8'h11, 8'h22};
    send_tx(100, 1'b1, 0);
    drain();
    chk("clr_cnt", 32'(popped_q.size()), 32'd1);
    chk("clr_word", 32'(popped_q[0]), 32'h21122);
    chk("clr_next_len", 32'(frame_len_o), 32'd2);

    // Asynchronous reset mid-frame
    popped_q.delete();
    tx_q = '{8'h01, 8'h02, 8'h03};
    send_tx(0, 1'b0, 0);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_level", 32'(level_o), 32'd0);
    chk("arst_valid", 32'(word_valid_o), 32'd0);
    chk("arst_len", 32'(frame_len_o), 32'd0);
    chk("arst_done", 32'(frame_done_o), 32'd0);
    @(negedge clk);
    #1 rst_i = 1'b0;
    tx_q = '{8'hC3, 8'h3C, 8'h99};
    send_tx(100, 1'b1, 0);
    drain();
    chk("arst_cnt", 32'(popped_q.size()), 32'd2);
    chk("arst_w0", 32'(popped_q[0]), 32'h0C33C);
    chk("arst_w1", 32'(popped_q[1]), 32'h39900);
    chk("arst_next_len", 32'(frame_len_o), 32'd3);

    // Random frames with random consumer stalls
    popped_q.delete();
    total = 0;
    n = 0;
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(9, 1);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      send_tx(60, 1'b1, 0);
      total += (n + 1) / 2;
    end
    drain();
    chk("rnd_cnt", 32'(popped_q.size()), 32'(total));
    chk("rnd_len", 32'(frame_len_o), 32'(n));
    chk("rnd_empty", 32'(level_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
